// File: rtl/dmem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_pkg
// Shared definitions for the data-memory access controller:
//   - mem_op_e     : load/store operation encodings (LW..SB)
//   - ctrl_state_e : controller FSM state encodings
//   - RAM_* / ZERO_WORD : memory control and data constants
//   - helpers that classify an operation and check its alignment
// -----------------------------------------------------------------------------
package dmem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } ctrl_state_e;

  localparam logic        RAM_ENABLE  = 1'b1;
  localparam logic        RAM_DISABLE = 1'b0;
  localparam logic        RAM_WRITE   = 1'b1;
  localparam logic        RAM_READ    = 1'b0;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  function automatic logic is_load(input mem_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Words need a 4-byte boundary, halfwords a 2-byte boundary.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
    logic bad;
    case (op)
      OP_LW, OP_SW:         bad = (addr_lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = addr_lo[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_fmt.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_lane_fmt
// Combinational little-endian lane logic, shared with the writeback path.
//   op_i        : operation (mem_op_e)
//   addr_lo_i   : byte offset within the word
//   rd_word_i   : word read from memory (load source and merge base)
//   wdata_i     : store data, sub-word stores use the low bits
//   load_data_o : extracted and sign/zero-extended load result
//   store_word_o: rd_word_i with the addressed lane(s) replaced
// -----------------------------------------------------------------------------
module dmem_access_ctrl_lane_fmt
  import dmem_access_ctrl_pkg::*;
(
  input  mem_op_e     op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [4:0]  byte_lsb;
  logic [4:0]  half_lsb;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_lsb = {addr_lo_i, 3'b000};
  assign half_lsb = {addr_lo_i[1], 4'b0000};
  assign byte_v   = rd_word_i[byte_lsb +: 8];
  assign half_v   = rd_word_i[half_lsb +: 16];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    load_data_o = ZERO_WORD;
    case (op_i)
      OP_LW:   load_data_o = rd_word_i;
      OP_LH:   load_data_o = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_data_o = {16'h0000, half_v};
      OP_LB:   load_data_o = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_data_o = {24'h000000, byte_v};
      default: load_data_o = ZERO_WORD;
    endcase
  end

  always_comb begin
    store_word_o = rd_word_i;
    case (op_i)
      OP_SW:   store_word_o = wdata_i;
      OP_SH:   store_word_o[half_lsb +: 16] = wdata_i[15:0];
      OP_SB:   store_word_o[byte_lsb +: 8]  = wdata_i[7:0];
      default: store_word_o = rd_word_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage initiator for the word-wide data memory. Takes one load/store at a
// time over valid/ready, performs sub-word loads by lane extraction and
// sub-word stores by read-modify-write, and returns one response per request.
// req_ready low doubles as the pipeline stall request.
//   clk, rst           : clock, synchronous active-low reset
//   req_*              : request channel (valid/ready, op, byte address, data)
//   resp_*             : one-cycle response pulse, load data, misalign error
//   mem_*              : registered memory controls, combinational read data
// -----------------------------------------------------------------------------
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  ctrl_state_e       state_q;
  mem_op_e           op_q;
  logic [1:0]        addr_lo_q;
  logic [DATA_W-1:0] wdata_q;

  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic              mem_ce_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  mem_op_e           req_op_e;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;

  assign req_op_e  = mem_op_e'(req_op);
  assign req_ready = (state_q == ST_IDLE);

  // The read word feeds both the load extractor (in LOAD) and the merge (in
  // RMW_RD); the latched op selects which result is used.
  dmem_access_ctrl_lane_fmt u_lane_fmt (
    .op_i         (op_q),
    .addr_lo_i    (addr_lo_q),
    .rd_word_i    (mem_rdata),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LW;
      addr_lo_q    <= 2'b00;
      wdata_q      <= ZERO_WORD;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= ZERO_WORD;
      resp_err_q   <= 1'b0;
      mem_ce_q     <= RAM_DISABLE;
      mem_we_q     <= RAM_READ;
      mem_addr_q   <= '0;
      mem_wdata_q  <= ZERO_WORD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op_e;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            if (is_misaligned(req_op_e, req_addr[1:0])) begin
              // Rejected without touching memory.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= ZERO_WORD;
              state_q      <= ST_RESP;
            end else begin
              mem_ce_q   <= RAM_ENABLE;
              mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
              if (is_load(req_op_e)) begin
                mem_we_q <= RAM_READ;
                state_q  <= ST_LOAD;
              end else if (req_op_e == OP_SW) begin
                mem_we_q    <= RAM_WRITE;
                mem_wdata_q <= req_wdata;
                state_q     <= ST_STORE;
              end else begin
                // SH/SB: fetch the old word first, memory only writes words.
                mem_we_q <= RAM_READ;
                state_q  <= ST_RMW_RD;
              end
            end
          end
        end
        ST_LOAD: begin
          mem_ce_q     <= RAM_DISABLE;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_data;
          state_q      <= ST_RESP;
        end
        ST_STORE, ST_RMW_WR: begin
          mem_ce_q     <= RAM_DISABLE;
          mem_we_q     <= RAM_READ;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= ZERO_WORD;
          state_q      <= ST_RESP;
        end
        ST_RMW_RD: begin
          mem_we_q    <= RAM_WRITE;
          mem_wdata_q <= store_word;
          state_q     <= ST_RMW_WR;
        end
        ST_RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          mem_ce_q     <= RAM_DISABLE;
          mem_we_q     <= RAM_READ;
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_ce     = mem_ce_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Directed bench for dmem_access_ctrl with a small word memory model.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  // Memory model and activity counters, sampled at the active edge.
  logic [31:0] mem [64];
  int          wr_cnt = 0;
  int          ce_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] last_wr_addr = '0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_ce && mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_cnt = wr_cnt + 1;
      last_wr_addr = mem_addr;
    end
    if (mem_ce) ce_cnt = ce_cnt + 1;
    if (resp_valid) resp_cnt = resp_cnt + 1;
  end

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and waits (bounded) for its response. lat is the
  // cycle index after the acceptance edge, 0 if no response arrived.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int lat);
    lat = 0;
    rd  = '0;
    err = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        rd  = resp_rdata;
        err = resp_err;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          wr0, ce0, resp0;
  int          hits [2];
  int          nhits;

  initial begin
    // Reset held for two cycles.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_ce_cycles", ce_cnt, 32'd0);
    rst = 1'b1;

    // SW then LW at 0x10.
    wr0 = wr_cnt; resp0 = resp_cnt;
    do_req(SW, 32'h10, 32'hDEADBEEF, rd, err, lat);
    check("sw_lat", lat, 32'd2);
    check("sw_rdata", rd, 32'd0);
    check("sw_writes", wr_cnt - wr0, 32'd1);
    check("sw_wr_addr", last_wr_addr, 32'h10);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    @(negedge clk);
    check("sw_one_resp", resp_cnt - resp0, 32'd1);
    wr0 = wr_cnt;
    do_req(LW, 32'h10, 32'h0, rd, err, lat);
    check("lw_lat", lat, 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", {31'd0, err}, 32'd0);
    check("lw_no_write", wr_cnt - wr0, 32'd0);

    // Sub-word loads.
    do_req(SW, 32'h20, 32'h11223344, rd, err, lat);
    do_req(SW, 32'h24, 32'h80005684, rd, err, lat);
    do_req(LB, 32'h23, 32'h0, rd, err, lat);
    check("lb_23", rd, 32'h00000011);
    check("lb_lat", lat, 32'd2);
    do_req(LH, 32'h22, 32'h0, rd, err, lat);
    check("lh_22", rd, 32'h00001122);
    do_req(LB, 32'h24, 32'h0, rd, err, lat);
    check("lb_24_neg", rd, 32'hFFFFFF84);
    do_req(LBU, 32'h24, 32'h0, rd, err, lat);
    check("lbu_24", rd, 32'h00000084);
    do_req(LH, 32'h26, 32'h0, rd, err, lat);
    check("lh_26_neg", rd, 32'hFFFF8000);
    do_req(LHU, 32'h26, 32'h0, rd, err, lat);
    check("lhu_26", rd, 32'h00008000);
    do_req(LB, 32'h25, 32'h0, rd, err, lat);
    check("lb_25", rd, 32'h00000056);

    // Read-modify-write stores.
    do_req(SW, 32'h30, 32'hAABBCCDD, rd, err, lat);
    wr0 = wr_cnt; ce0 = ce_cnt;
    do_req(SB, 32'h31, 32'h00000055, rd, err, lat);
    check("sb_lat", lat, 32'd3);
    check("sb_writes", wr_cnt - wr0, 32'd1);
    check("sb_ce_cycles", ce_cnt - ce0, 32'd2);
    check("sb_wr_addr", last_wr_addr, 32'h30);
    check("sb_mem", mem[12], 32'hAABB55DD);
    check("sb_rdata", rd, 32'd0);
    do_req(SH, 32'h32, 32'hFFFF1234, rd, err, lat);
    check("sh_lat", lat, 32'd3);
    check("sh_mem", mem[12], 32'h123455DD);

    // Misaligned requests.
    ce0 = ce_cnt;
    do_req(LW, 32'h42, 32'h0, rd, err, lat);
    check("lw_mis_err", {31'd0, err}, 32'd1);
    check("lw_mis_rdata", rd, 32'd0);
    check("lw_mis_lat", lat, 32'd1);
    do_req(SH, 32'h41, 32'h0000BEEF, rd, err, lat);
    check("sh_mis_err", {31'd0, err}, 32'd1);
    check("sh_mis_lat", lat, 32'd1);
    check("mis_no_ce", ce_cnt - ce0, 32'd0);
    // Error flag holds after the pulse, then clears on the next good response.
    @(negedge clk);
    check("err_hold", {31'd0, resp_err}, 32'd1);
    do_req(LW, 32'h10, 32'h0, rd, err, lat);
    check("err_clear", {31'd0, err}, 32'd0);

    // req_valid held across RESP: the second accept waits for the edge
    // that ends RESP, giving responses in cycles 2 and 5.
    nhits = 0;
    hits[0] = 0; hits[1] = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = LW; req_addr = 32'h10; req_wdata = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (resp_valid && nhits < 2) begin
        hits[nhits] = k;
        nhits++;
      end
    end
    req_valid = 1'b0;
    check("b2b_first", hits[0], 32'd2);
    check("b2b_second", hits[1], 32'd5);
    repeat (2) @(negedge clk);

    // Reset during RMW_RD of an SB.
    @(negedge clk);
    req_valid = 1'b1; req_op = SB; req_addr = 32'h30; req_wdata = 32'hEE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rmw_rd_ce", {31'd0, mem_ce}, 32'd1);
    wr0 = wr_cnt; resp0 = resp_cnt;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_ce", {31'd0, mem_ce}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_writes", wr_cnt - wr0, 32'd0);
    check("mid_rst_resp", resp_cnt - resp0, 32'd0);
    check("mid_rst_mem", mem[12], 32'h123455DD);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    do_req(LW, 32'h30, 32'h0, rd, err, lat);
    check("post_rst_lw", rd, 32'h123455DD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound in case a wait loop is ever broken.
  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

endmodule
